// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state enum, the NOP reset word and the IF/ID payload struct.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetch_state_e;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } if_id_t;

    // Instruction addresses must be word aligned.
    function automatic logic pc_aligned(input word_t pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load captures a fetched word, clear drops the valid bit,
// otherwise contents hold.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter word_t RESET_INSTR = NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_load,
    input  logic   i_clear,
    input  if_id_t i_data,
    output logic   o_valid,
    output if_id_t o_data
);

    logic   r_valid;
    if_id_t r_data;

    // Load wins over clear; clear leaves the payload untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_data.instr <= RESET_INSTR;
            r_data.pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one imem request at a time for pc_in, captures the
// response into the IF/ID register and handles flush/redirect and misaligned PCs.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter word_t RESET_INSTR = NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic        pc_advance,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        flush,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        fetch_err
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    word_t        r_pc_q;
    logic         r_fetch_err;
    logic         w_fetch_err_nxt;
    logic         w_req_valid;
    logic         w_hs;
    logic         w_load;
    logic         w_clear;
    if_id_t       w_if_in;
    if_id_t       w_if_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, request strobe and IF/ID control.
    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_err_nxt = r_fetch_err;
        w_req_valid     = 1'b0;
        w_hs            = 1'b0;
        w_load          = 1'b0;
        w_clear         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (pc_aligned(pc_in)) begin
                    w_req_valid = 1'b1;
                    if (imem_req_ready) begin
                        w_hs        = 1'b1;
                        w_state_nxt = flush ? S_DROP : S_WAIT;
                    end
                end else begin
                    w_fetch_err_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (flush) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (flush) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_HOLD: begin
                if (flush || id_ready) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                // The in-flight response is the one to discard, even under a new flush.
                if (imem_rsp_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (flush) begin
            w_fetch_err_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_q      <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            if (w_hs) begin
                r_pc_q <= pc_in;
            end
            r_fetch_err <= w_fetch_err_nxt;
        end
    end

    assign w_if_in.instr = imem_rsp_data;
    assign w_if_in.pc    = r_pc_q;

    if_id_reg #(
        .RESET_INSTR (RESET_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_data  (w_if_in),
        .o_valid (if_valid),
        .o_data  (w_if_out)
    );

    assign if_instr       = w_if_out.instr;
    assign if_pc          = w_if_out.pc;
    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = pc_in;
    assign pc_advance     = w_hs & ~flush;
    assign fetch_err      = r_fetch_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID words are queued by the stimulus and
// checked by an independent monitor whenever if_valid rises.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        fetch_err;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_adv = 0;
    int   exp_adv = 0;
    int   adv0 = 0;
    logic prev_valid = 1'b0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage #(
        .RESET_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_in          (pc_in),
        .pc_advance     (pc_advance),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .flush          (flush),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: each new IF/ID instruction must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (if_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_if_valid: got pc %h instr %h expected none", if_pc, if_instr);
            end else begin
                e = q.pop_front();
                chk("mon_if_pc", if_pc, e.pc);
                chk("mon_if_instr", if_instr, e.instr);
            end
        end
        prev_valid = if_valid;
    end

    // Count accepted PC advances just before each rising edge.
    always @(negedge clk) begin
        #4;
        if (pc_advance === 1'b1) n_adv++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b0;
        pc_in          = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        flush          = 1'b0;
        id_ready       = 1'b0;

        // Reset values
        repeat (3) tick();
        #1;
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, NOP);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_pc_advance", 32'(pc_advance), 32'd0);
        imem_req_ready = 1'b0;
        reset = 1'b1;

        // Basic fetch at pc 0
        tick();
        #1;
        chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_req_addr", imem_req_addr, 32'h0);
        imem_req_ready = 1'b1;
        q.push_back('{pc: 32'h0, instr: 32'h0050_0093});
        exp_adv++;
        #1;
        chk("t1_pc_advance", 32'(pc_advance), 32'd1);
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0050_0093;
        id_ready       = 1'b1;
        #1;
        chk("t1_wait_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        chk("t1_if_valid", 32'(if_valid), 32'd1);
        tick();
        #1;
        chk("t1_hold_to_req", 32'(imem_req_valid), 32'd1);
        chk("t1_if_valid_cleared", 32'(if_valid), 32'd0);
        chk("t1_adv_count", 32'(n_adv), 32'd1);
        id_ready = 1'b0;
        pc_in    = 32'h4;

        // Stall in HOLD for 5 cycles
        imem_req_ready = 1'b1;
        q.push_back('{pc: 32'h4, instr: 32'h00a0_0113});
        exp_adv++;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00a0_0113;
        tick();
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        adv0 = n_adv;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_hold_valid", 32'(if_valid), 32'd1);
            chk("t2_hold_instr", if_instr, 32'h00a0_0113);
            chk("t2_hold_pc", if_pc, 32'h4);
            chk("t2_hold_no_req", 32'(imem_req_valid), 32'd0);
            if (i == 2) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'h1234_5678;
            end
            tick();
            imem_rsp_valid = 1'b0;
        end
        #1;
        chk("t2_no_advance", 32'(n_adv), 32'(adv0));
        chk("t2_instr_after_stray_rsp", if_instr, 32'h00a0_0113);
        imem_req_ready = 1'b0;
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;

        // Flush in WAIT, late response dropped, redirect to 0x100
        pc_in = 32'h8;
        imem_req_ready = 1'b1;
        exp_adv++;
        tick();
        imem_req_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pc_in = 32'h100;
        #1;
        chk("t3_drop_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t3_req_addr", imem_req_addr, 32'h100);
        chk("t3_if_valid", 32'(if_valid), 32'd0);
        imem_req_ready = 1'b1;
        q.push_back('{pc: 32'h100, instr: 32'h0000_0011});
        exp_adv++;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0011;
        id_ready       = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        tick();
        id_ready = 1'b0;

        // Flush in the handshake cycle
        pc_in = 32'h104;
        imem_req_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_pc_advance", 32'(pc_advance), 32'd0);
        tick();
        imem_req_ready = 1'b0;
        flush = 1'b0;
        #1;
        chk("t4_drop_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        chk("t4_back_to_req", 32'(imem_req_valid), 32'd1);
        chk("t4_if_valid", 32'(if_valid), 32'd0);

        // Misaligned PC
        pc_in = 32'h102;
        imem_req_ready = 1'b1;
        #1;
        chk("t5_no_req", 32'(imem_req_valid), 32'd0);
        chk("t5_no_adv", 32'(pc_advance), 32'd0);
        chk("t5_err_not_yet", 32'(fetch_err), 32'd0);
        tick();
        #1;
        chk("t5_err_set", 32'(fetch_err), 32'd1);
        chk("t5_still_no_req", 32'(imem_req_valid), 32'd0);
        imem_req_ready = 1'b0;
        flush = 1'b1;
        pc_in = 32'h108;
        tick();
        flush = 1'b0;
        #1;
        chk("t5_err_cleared", 32'(fetch_err), 32'd0);

        // Flush in HOLD overrides id_ready=0 and clears if_valid
        imem_req_ready = 1'b1;
        q.push_back('{pc: 32'h108, instr: 32'h0030_8193});
        exp_adv++;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0030_8193;
        tick();
        imem_rsp_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("t6_hold_flush_clear", 32'(if_valid), 32'd0);
        chk("t6_req_after_flush", 32'(imem_req_valid), 32'd1);

        // Flush together with the response in WAIT
        pc_in = 32'h10c;
        imem_req_ready = 1'b1;
        exp_adv++;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hFFFF_FFFF;
        flush = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("t7_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t7_if_valid", 32'(if_valid), 32'd0);

        // Reset during WAIT, late response after release ignored
        pc_in = 32'h110;
        imem_req_ready = 1'b1;
        exp_adv++;
        tick();
        reset = 1'b0;
        #1;
        chk("t8_rst_if_valid", 32'(if_valid), 32'd0);
        chk("t8_rst_if_instr", if_instr, NOP);
        chk("t8_rst_if_pc", if_pc, 32'h0);
        chk("t8_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t8_rst_pc_advance", 32'(pc_advance), 32'd0);
        imem_req_ready = 1'b0;
        tick();
        reset = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        chk("t8_late_if_valid", 32'(if_valid), 32'd0);
        chk("t8_late_if_instr", if_instr, NOP);
        chk("t8_req_after_reset", 32'(imem_req_valid), 32'd1);

        tick();
        chk("total_pc_advance", 32'(n_adv), 32'(exp_adv));
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_INSTR, default 32'h0000_0013 (NOP), SHALL be the value driven on if_instr whenever no instruction has been loaded since reset.
REQ-002 clk  in  1  clock; all state SHALL update on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 pc_in  in  32  current PC from the program counter register.
REQ-005 pc_advance  out  1  one-cycle pulse; the upstream PC register SHALL load its next address only when this is high.
REQ-006 imem_req_valid  out  1  instruction-memory request valid.
REQ-007 imem_req_addr  out  32  request address, equal to pc_in.
REQ-008 imem_req_ready  in  1  memory accepts the request.
REQ-009 imem_rsp_valid  in  1  response data valid, single-cycle pulse.
REQ-010 imem_rsp_data  in  32  fetched instruction word.
REQ-011 flush  in  1  redirect: discard held and in-flight instructions.
REQ-012 if_valid  out  1  IF/ID register holds a valid instruction.
REQ-013 if_instr  out  32  IF/ID instruction.
REQ-014 if_pc  out  32  PC of if_instr.
REQ-015 id_ready  in  1  decode consumes if_instr this cycle.
REQ-016 fetch_err  out  1  sticky misaligned-PC error.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DROP.
REQ-018 IDLE SHALL go to REQ on the cycle after reset deasserts.
REQ-019 REQ: imem_req_valid=1 when pc_in[1:0]==0; otherwise imem_req_valid=0, fetch_err set next edge, state held.
REQ-020 Handshake SHALL complete when imem_req_valid & imem_req_ready; pc_in SHALL be latched into pc_q, and state SHALL go to WAIT.
REQ-021 pc_advance SHALL be combinational imem_req_valid & imem_req_ready & ~flush.
REQ-022 Handshake with flush in the same cycle: pc_advance=0, state SHALL go to DROP.
REQ-023 WAIT, imem_rsp_valid, no flush: if_instr<=imem_rsp_data, if_pc<=pc_q, if_valid<=1, state to HOLD.
REQ-024 HOLD: if_valid, if_instr, if_pc SHALL stay stable while id_ready=0; on id_ready=1, if_valid<=0 and state to REQ.
REQ-025 Latency: response to if_valid SHALL be 1 cycle; HOLD with id_ready=1 to next imem_req_valid SHALL be 1 cycle.
REQ-026 Flush in WAIT without rsp: state to DROP; flush in WAIT with rsp same cycle: response discarded, state to REQ.
REQ-027 DROP SHALL discard the next imem_rsp_valid and go to REQ; flush in DROP SHALL keep DROP.
REQ-028 Flush in HOLD SHALL clear if_valid and go to REQ; flush SHALL override id_ready.
REQ-029 Flush in REQ/IDLE without handshake SHALL leave state unchanged; flush SHALL clear fetch_err.
REQ-030 imem_rsp_valid in IDLE, REQ or HOLD SHALL be ignored.
REQ-031 At most one request SHALL be outstanding.

Reset
REQ-032 Reset assertion SHALL asynchronously force state IDLE, if_valid=0, if_instr=RESET_INSTR, if_pc=0, pc_q=0, fetch_err=0.
REQ-033 imem_req_valid and pc_advance SHALL be 0 throughout reset; a response arriving after reset deassertion for a pre-reset request SHALL be ignored (IDLE).

Structure
REQ-034 Package fetch_pkg SHALL hold the state enum, the NOP constant and the 32-bit word typedef.
REQ-035 IF/ID register (if_valid/if_instr/if_pc with load, clear, hold) SHALL be sub-module if_id_reg.

Verification
REQ-036 pc_in=0x0, req_ready=1, rsp 1 cycle later with 0x00500093, id_ready=1 -> if_valid with if_pc=0x0, if_instr=0x00500093; one pc_advance pulse.
REQ-037 id_ready=0 for 5 cycles in HOLD -> outputs stable, imem_req_valid=0, no pc_advance.
REQ-038 flush in WAIT, rsp 0xDEADBEEF 2 cycles later -> if_valid never set; next request at new pc_in=0x100.
REQ-039 flush same cycle as handshake -> pc_advance=0, following response dropped.
REQ-040 pc_in=0x102 -> no request, fetch_err=1 next edge; flush -> fetch_err=0.
REQ-041 reset low during WAIT -> immediate IDLE, if_instr=0x00000013, late response ignored.
